// File: rtl/simple_acc_reduce.sv
// Stream reduction stage: sums a run of len_i products modulo 2^DataWidth
// and presents the single sum on a valid-ready output port.
module simple_acc_reduce #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CntWidth-1:0]  len_i,
  output logic                 busy_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [DataWidth-1:0] acc_o,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0]  CntZero = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0]  CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [DataWidth-1:0] AccZero = {DataWidth{1'b0}};

  state_e               state_q, state_d;
  logic [DataWidth-1:0] acc_q, acc_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [CntWidth-1:0]  len_q, len_d;
  logic                 done_q, done_d;
  logic                 in_hs;
  logic                 out_hs;
  logic                 last_elem;

  // Handshake qualifiers; ready/valid themselves depend on state only.
  assign in_hs     = data_valid_i && data_ready_o;
  assign out_hs    = acc_valid_o && acc_ready_i;
  assign last_elem = (cnt_q == (len_q - CntOne));

  // Next-state and datapath update for the run sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && (len_i != CntZero)) begin
          len_d   = len_i;
          acc_d   = AccZero;
          cnt_d   = CntZero;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (in_hs) begin
          acc_d = acc_q + data_i;
          cnt_d = cnt_q + CntOne;
          if (last_elem) begin
            state_d = OUT;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      OUT: begin
        if (out_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset discards any partial run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= AccZero;
      cnt_q   <= CntZero;
      len_q   <= CntZero;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign data_ready_o = (state_q == ACC);
  assign acc_valid_o  = (state_q == OUT);
  assign acc_o        = acc_q;
  assign done_o       = done_q;

endmodule

// File: doc/simple_acc_reduce.md
# simple_acc_reduce

Stream reduction stage that sits directly downstream of the simple multiplier in the simple accelerator. It consumes a run of `len` products over a valid-ready port and sums them modulo 2^DataWidth. It then presents the single sum on a valid-ready output port. Each run is started by a `start_i` pulse, so the block turns the multiplier into a dot-product engine.

## Interface
- `DataWidth`, 64: width of input products and of the accumulator/result.
- `CntWidth`, 8: width of the run-length field; maximum run is 2^CntWidth-1 elements.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: single-cycle run request, sampled only in IDLE.
- `len_i` in CntWidth: number of elements in the run, sampled with `start_i`.
- `busy_o` out 1: high in ACC or OUT.
- `data_i` in DataWidth: input element (multiplier `result_o`).
- `data_valid_i` in 1: input valid.
- `data_ready_o` out 1: input ready.
- `acc_o` out DataWidth: accumulated sum.
- `acc_valid_o` out 1: sum valid.
- `acc_ready_i` in 1: sum consumer ready.
- `done_o` out 1: one-cycle pulse the cycle after the sum handshake.

## Operation
- Registers: `state` {IDLE, ACC, OUT}, `acc_q[DataWidth]`, `cnt_q[CntWidth]`, `len_q[CntWidth]`, `done_q`.
- Input handshake (`in_hs`) = `data_valid_i && data_ready_o`.
- Output handshake (`out_hs`) = `acc_valid_o && acc_ready_i`.

IDLE:
- `data_ready_o`=0 and `acc_valid_o`=0.
- On `start_i` with `len_i`!=0: `len_q`<=`len_i`, `acc_q`<=0, `cnt_q`<=0, go to ACC.
- On `start_i` with `len_i`==0: the request is ignored and the state stays IDLE.

ACC:
- `data_ready_o`=1. It is driven from state only, with no combinational path from `data_valid_i`.
- On `in_hs`: `acc_q`<=`acc_q`+`data_i`, truncated to DataWidth (wraps, no saturation); `cnt_q`<=`cnt_q`+1.
- If `in_hs` and `cnt_q`==`len_q`-1: go to OUT.
- Cycles without `data_valid_i` leave all registers unchanged.

OUT:
- `acc_valid_o`=1 and `data_ready_o`=0.
- `acc_o`=`acc_q` and must hold stable until `out_hs`.
- On `out_hs`: go to IDLE and set `done_q`<=1.

Other rules:
- `done_o`=`done_q`; it is cleared the following cycle unless re-set.
- `start_i` in ACC or OUT is ignored. There is no queuing and `len_q` is unchanged.
- `acc_o` drives `acc_q` in all states; it is meaningful only while `acc_valid_o`=1.
- `busy_o` = (state != IDLE).

## Timing
- Reset values: state=IDLE, `acc_q`=0, `cnt_q`=0, `len_q`=0, `done_q`=0. Outputs at reset: `busy_o`=0, `data_ready_o`=0, `acc_valid_o`=0, `acc_o`=0, `done_o`=0.
- `start_i` at edge t gives `busy_o`=1 and `data_ready_o`=1 from cycle t+1.
- Throughput: one element accepted per cycle in ACC.
- Latency: last input handshake at edge t gives `acc_valid_o`=1 in cycle t+1.
- Minimum run length 1: `start_i` at t, input handshake at t+1, `acc_valid_o` at t+2.
- `out_hs` at edge t gives `done_o`=1 and `busy_o`=0 in cycle t+1. A new `start_i` is accepted in that same cycle t+1.
- `acc_ready_i` held high before entering OUT: the sum is consumed in the first OUT cycle, giving a 1-cycle OUT dwell.
- Backpressure: `acc_valid_o` and `acc_o` stay constant for any number of cycles with `acc_ready_i`=0.
- `len_i`=2^CntWidth-1 (255): the counter reaches 254 and transitions correctly with no counter overflow.
- Asynchronous reset mid-run (ACC or OUT): return immediately to IDLE with all outputs at reset values. The partial sum is discarded and no `done_o` is issued.

## Test plan
- Reset: assert `rst_ni`=0 mid-ACC with `acc_q`!=0 → all outputs 0 immediately. After release, `data_ready_o` stays 0 until `start_i`.
- Basic run: `start_i`, `len_i`=4; data 3,5,7,11 back-to-back with valid=1 and `acc_ready_i`=1 → `acc_o`=26, `acc_valid_o` for 1 cycle exactly 1 cycle after the 4th handshake, then `done_o` 1-cycle pulse.
- Bubbles and backpressure: `len_i`=3; data 10, 20, 30 with 2 idle cycles between elements; `acc_ready_i`=0 for 5 cycles → `acc_o`=60 held stable for all 5 cycles, `busy_o`=1 throughout, single `done_o` after `acc_ready_i`=1.
- Wrap and length edges (DataWidth=64):
  - `len_i`=2, data 0xFFFF_FFFF_FFFF_FFFF and 2 → `acc_o`=1.
  - `len_i`=1, data 42 → `acc_o`=42.
  - `len_i`=0 → no state change, `busy_o` stays 0.
- Ignored start: pulse `start_i` with `len_i`=9 during ACC of a `len_i`=2 run (data 1,1) → `acc_o`=2, run ends after 2 elements, returns to IDLE.
- Chained with the multiplier: connect to a multiplier fed a=1..4 and b=2 → `acc_o`=20. Next run starts the cycle after `done_o` and yields a fresh sum with no residue from the previous run.
